// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path definitions: default widths, the NOP encoding and
// the layout of the two-bit fault code returned with every fetch response.
package mips_pkg;

  localparam int          DATA_W_DEF     = 32;
  localparam int          ADDR_W_DEF     = 32;
  localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;

  localparam int          FAULT_W        = 2;
  localparam int          FAULT_MISALIGN = 0;
  localparam int          FAULT_RANGE    = 1;

  typedef logic [FAULT_W-1:0] fault_t;

  function automatic fault_t f_make_fault(input logic misalign, input logic out_of_range);
    fault_t f;
    f                 = '0;
    f[FAULT_MISALIGN] = misalign;
    f[FAULT_RANGE]    = out_of_range;
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_pipe_if.sv
// Fetch-side request/response bus between the PC stage (master) and the
// instruction memory (slave).
interface instr_mem_pipe_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [ADDR_W-1:0] rsp_addr;
  fault_t            rsp_fault;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_fault
  );

endinterface

// File: rtl/imem_stage.sv
// One delay stage of the fetch response pipeline: shifts on advance, holds
// on stall, and drops its valid bit when the pipeline is flushed.
module imem_stage
  import mips_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_hold,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  fault_t            i_fault,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output fault_t            o_fault,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  fault_t            r_fault;
  logic [DATA_W-1:0] r_data;

  // Payload only loads when a valid entry moves in, so an idle stage keeps
  // presenting its last contents instead of toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_fault <= '0;
      r_data  <= NOP_WORD;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (!i_hold) begin
        r_valid <= i_valid;
      end
      if (!i_hold && i_valid) begin
        r_addr  <= i_addr;
        r_fault <= i_fault;
        r_data  <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_fault = r_fault;
  assign o_data  = r_data;

endmodule

// File: rtl/instr_mem_pipe.sv
// Clocked instruction memory for the fetch stage: request/response handshake,
// LATENCY-deep response pipeline, program-load write port and fault reporting.
module instr_mem_pipe
  import mips_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DEPTH     = 256,
  parameter int                LATENCY   = 1,
  parameter int                BYTE_ADDR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  instr_mem_pipe_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  function automatic logic [ADDR_W-1:0] f_word_idx(input logic [ADDR_W-1:0] addr);
    return (BYTE_ADDR != 0) ? (addr >> 2) : addr;
  endfunction

  logic              w_adv;
  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_req_idx;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_req_mis;
  logic              w_req_oor;
  logic              w_wr_oor;
  fault_t            w_req_fault;

  logic              w_vld   [LATENCY];
  logic [ADDR_W-1:0] w_addr  [LATENCY];
  fault_t            w_fault [LATENCY];
  logic [DATA_W-1:0] w_data  [LATENCY];

  logic              r_vld_p0;
  logic [ADDR_W-1:0] r_addr_p0;
  fault_t            r_fault_p0;
  logic [DATA_W-1:0] r_data_p0;

  // Not reset: program contents must survive a pipeline reset.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: NOP_WORD};

  // DEPTH is a power of two, so any set bit above the index width means the
  // word lies outside the array; indices never wrap onto low words.
  assign w_req_idx   = f_word_idx(bus.req_addr);
  assign w_wr_idx    = f_word_idx(wr_addr);
  assign w_req_mis   = (BYTE_ADDR != 0) && (bus.req_addr[1:0] != 2'b00);
  assign w_req_oor   = |w_req_idx[ADDR_W-1:IDX_W];
  assign w_wr_oor    = |w_wr_idx[ADDR_W-1:IDX_W];
  assign w_req_fault = f_make_fault(w_req_mis, w_req_oor);

  assign w_adv     = !w_vld[LATENCY-1] || bus.rsp_ready;
  assign w_ready   = w_adv && !flush;
  assign w_accept  = bus.req_valid && w_ready;
  assign bus.req_ready = w_ready;

  always_ff @(posedge clk) begin
    if (wr_en && !w_wr_oor) begin
      r_mem[w_wr_idx[IDX_W-1:0]] <= wr_data;
    end
  end

  // ---- stage p0: memory read at the accept edge (read-first vs. write) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0   <= 1'b0;
      r_addr_p0  <= '0;
      r_fault_p0 <= '0;
      r_data_p0  <= NOP_WORD;
    end else begin
      if (flush) begin
        r_vld_p0 <= 1'b0;
      end else if (w_adv) begin
        r_vld_p0 <= w_accept;
      end
      if (w_accept) begin
        r_addr_p0  <= bus.req_addr;
        r_fault_p0 <= w_req_fault;
        r_data_p0  <= (|w_req_fault) ? NOP_WORD : r_mem[w_req_idx[IDX_W-1:0]];
      end
    end
  end

  assign w_vld[0]   = r_vld_p0;
  assign w_addr[0]  = r_addr_p0;
  assign w_fault[0] = r_fault_p0;
  assign w_data[0]  = r_data_p0;

  // ---- stages p1..p(LATENCY-1): pure delay ----
  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    imem_stage #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NOP_WORD (NOP_WORD)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_hold  (!w_adv),
      .i_clear (flush),
      .i_valid (w_vld[g-1]),
      .i_addr  (w_addr[g-1]),
      .i_fault (w_fault[g-1]),
      .i_data  (w_data[g-1]),
      .o_valid (w_vld[g]),
      .o_addr  (w_addr[g]),
      .o_fault (w_fault[g]),
      .o_data  (w_data[g])
    );
  end

  assign bus.rsp_valid = w_vld[LATENCY-1];
  assign bus.rsp_addr  = w_addr[LATENCY-1];
  assign bus.rsp_fault = w_fault[LATENCY-1];
  assign bus.rsp_instr = w_data[LATENCY-1];

endmodule
